// File: rtl/xpat_eval_pkg.sv
// rtl/xpat_eval_pkg.sv - shared state type, sweep size and |a-b| helper for the XPAT error sweeper
// Contents: state_t (IDLE/SWEEP/DRAIN/DONE), N_IN_DEF, NVEC, abs_diff()
package xpat_eval_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int N_IN_DEF = 4;
    localparam int NVEC     = 2 ** N_IN_DEF;

    function automatic int unsigned abs_diff(input int unsigned x, input int unsigned y);
        return (x >= y) ? (x - y) : (y - x);
    endfunction

endpackage

// File: rtl/adder_error_sweeper_if.sv
// rtl/adder_error_sweeper_if.sv - stimulus/result link between the sweeper and the approximate adder
// Signals: stim (N_IN, pattern into the adder), approx_out (N_OUT, adder result)
// Modports: master = sweeper side, slave = adder side
interface adder_error_sweeper_if #(
    parameter int N_IN  = 4,
    parameter int N_OUT = 3
);
    logic [N_IN-1:0]  stim;
    logic [N_OUT-1:0] approx_out;

    modport master (output stim, input approx_out);
    modport slave  (input stim, output approx_out);
endinterface

// File: rtl/err_accum.sv
// rtl/err_accum.sv - accumulate-stage statistics registers for the error sweeper
// Ports: clk, rst_n (async active-low), i_clr (clear all stats), i_vld/i_err/i_tag (stage E result),
//        o_max_err, o_err_cnt, o_viol_cnt, o_sum_err, o_first_fail
module err_accum #(
    parameter int N_IN  = 4,
    parameter int N_OUT = 3,
    parameter int ET    = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_clr,
    input  logic                  i_vld,
    input  logic [N_OUT-1:0]      i_err,
    input  logic [N_IN-1:0]       i_tag,
    output logic [N_OUT-1:0]      o_max_err,
    output logic [N_IN:0]         o_err_cnt,
    output logic [N_IN:0]         o_viol_cnt,
    output logic [N_IN+N_OUT-1:0] o_sum_err,
    output logic [N_IN-1:0]       o_first_fail
);
    localparam logic [N_OUT-1:0] ET_W    = N_OUT'(ET);
    localparam logic [N_IN:0]    CNT_ONE = (N_IN+1)'(1);

    logic [N_OUT-1:0]      r_max_err;
    logic [N_IN:0]         r_err_cnt;
    logic [N_IN:0]         r_viol_cnt;
    logic [N_IN+N_OUT-1:0] r_sum_err;
    logic [N_IN-1:0]       r_first_fail;
    logic                  r_ff_set;    // first_fail already captured this sweep
    logic                  w_viol;

    assign w_viol = (i_err > ET_W);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_max_err    <= '0;
            r_err_cnt    <= '0;
            r_viol_cnt   <= '0;
            r_sum_err    <= '0;
            r_first_fail <= '0;
            r_ff_set     <= 1'b0;
        end else if (i_clr) begin
            r_max_err    <= '0;
            r_err_cnt    <= '0;
            r_viol_cnt   <= '0;
            r_sum_err    <= '0;
            r_first_fail <= '0;
            r_ff_set     <= 1'b0;
        end else if (i_vld) begin
            if (i_err > r_max_err) begin
                r_max_err <= i_err;
            end
            if (i_err != '0) begin
                r_err_cnt <= r_err_cnt + CNT_ONE;
            end
            if (w_viol) begin
                r_viol_cnt <= r_viol_cnt + CNT_ONE;
            end
            r_sum_err <= r_sum_err + {{N_IN{1'b0}}, i_err};
            if (w_viol && !r_ff_set) begin
                r_first_fail <= i_tag;
                r_ff_set     <= 1'b1;
            end
        end
    end

    assign o_max_err    = r_max_err;
    assign o_err_cnt    = r_err_cnt;
    assign o_viol_cnt   = r_viol_cnt;
    assign o_sum_err    = r_sum_err;
    assign o_first_fail = r_first_fail;
endmodule

// File: rtl/adder_error_sweeper.sv
// rtl/adder_error_sweeper.sv - exhaustive stimulus sweep and error statistics for an approximate adder
// Ports: clk, rst_n (async active-low), bus (master: stim out, approx_out in),
//        i_start, i_abort, o_busy, o_done, o_pass,
//        o_max_err, o_err_cnt, o_viol_cnt, o_sum_err, o_first_fail
module adder_error_sweeper
    import xpat_eval_pkg::*;
#(
    parameter int N_IN    = N_IN_DEF,
    parameter int N_OUT   = N_IN_DEF / 2 + 1,
    parameter int ET      = 2,
    parameter int RET_LAT = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    adder_error_sweeper_if.master bus,
    input  logic                  i_start,
    input  logic                  i_abort,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_pass,
    output logic [N_OUT-1:0]      o_max_err,
    output logic [N_IN:0]         o_err_cnt,
    output logic [N_IN:0]         o_viol_cnt,
    output logic [N_IN+N_OUT-1:0] o_sum_err,
    output logic [N_IN-1:0]       o_first_fail
);
    localparam int              HALF       = N_IN / 2;
    localparam logic [N_IN-1:0] LAST_VEC   = N_IN'((2 ** N_IN) - 1);
    localparam logic [N_IN-1:0] STIM_ONE   = N_IN'(1);
    localparam logic [2:0]      DRAIN_LAST = 3'(RET_LAT + 1);
    localparam logic [2:0]      DRAIN_ONE  = 3'(1);

    state_t          r_state;
    logic [N_IN-1:0] r_stim;
    logic [2:0]      r_drain;
    logic            r_busy;
    logic            r_done;
    logic            r_pass;

    logic            w_svld;     // stim carries a real vector this cycle
    logic            w_clr;      // accepted start: wipe stats
    logic            w_flush;    // drop every in-flight vector
    logic [N_IN-1:0] w_tag;      // stim delayed to line up with approx_out
    logic            w_tvld;
    logic [N_IN:0]   w_viol_cnt;

    assign w_svld  = (r_state == SWEEP);
    assign w_clr   = (r_state == IDLE) && i_start && !i_abort;
    assign w_flush = w_clr || (i_abort && ((r_state == SWEEP) || (r_state == DRAIN)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_stim  <= '0;
            r_drain <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_pass  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    // abort beats a simultaneous start
                    if (i_start && !i_abort) begin
                        r_state <= SWEEP;
                        r_stim  <= '0;
                        r_busy  <= 1'b1;
                        r_pass  <= 1'b0;
                    end
                end
                SWEEP: begin
                    if (i_abort) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                        r_pass  <= 1'b0;
                    end else if (r_stim == LAST_VEC) begin
                        r_state <= DRAIN;
                        r_drain <= '0;
                    end else begin
                        r_stim <= r_stim + STIM_ONE;
                    end
                end
                DRAIN: begin
                    // RET_LAT delay + stage E + stage A before the last vector lands
                    if (i_abort) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                        r_pass  <= 1'b0;
                    end else if (r_drain == DRAIN_LAST) begin
                        r_state <= DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_pass  <= (w_viol_cnt == '0);
                    end else begin
                        r_drain <= r_drain + DRAIN_ONE;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.stim = r_stim;
    assign o_busy   = r_busy;
    assign o_done   = r_done;
    assign o_pass   = r_pass;

    generate
        if (RET_LAT == 0) begin : g_nodly
            assign w_tag  = r_stim;
            assign w_tvld = w_svld;
        end else begin : g_dly
            logic [N_IN-1:0]    r_dtag [RET_LAT];
            logic [RET_LAT-1:0] r_dvld;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < RET_LAT; i++) begin
                        r_dtag[i] <= '0;
                    end
                    r_dvld <= '0;
                end else begin
                    r_dtag[0] <= r_stim;
                    r_dvld[0] <= w_svld && !w_flush;
                    for (int i = 1; i < RET_LAT; i++) begin
                        r_dtag[i] <= r_dtag[i-1];
                        r_dvld[i] <= r_dvld[i-1] && !w_flush;
                    end
                end
            end

            assign w_tag  = r_dtag[RET_LAT-1];
            assign w_tvld = r_dvld[RET_LAT-1];
        end
    endgenerate

    // Stage E: exact sum of the aligned vector and its distance from the adder result
    logic [N_OUT-1:0] w_a;
    logic [N_OUT-1:0] w_b;
    logic [N_OUT-1:0] w_exact;
    logic [N_OUT-1:0] w_err;
    logic             r_e_vld;
    logic [N_OUT-1:0] r_e_err;
    logic [N_IN-1:0]  r_e_tag;

    assign w_a     = N_OUT'(w_tag[HALF-1:0]);
    assign w_b     = N_OUT'(w_tag[N_IN-1:HALF]);
    assign w_exact = w_a + w_b;
    assign w_err   = N_OUT'(abs_diff(32'(w_exact), 32'(bus.approx_out)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_e_vld <= 1'b0;
            r_e_err <= '0;
            r_e_tag <= '0;
        end else begin
            r_e_vld <= w_tvld && !w_flush;
            r_e_err <= w_err;
            r_e_tag <= w_tag;
        end
    end

    err_accum #(
        .N_IN  (N_IN),
        .N_OUT (N_OUT),
        .ET    (ET)
    ) u_accum (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_clr        (w_clr),
        .i_vld        (r_e_vld),
        .i_err        (r_e_err),
        .i_tag        (r_e_tag),
        .o_max_err    (o_max_err),
        .o_err_cnt    (o_err_cnt),
        .o_viol_cnt   (w_viol_cnt),
        .o_sum_err    (o_sum_err),
        .o_first_fail (o_first_fail)
    );

    assign o_viol_cnt = w_viol_cnt;
endmodule

// File: tb/tb_adder_error_sweeper.sv
// tb/tb_adder_error_sweeper.sv - scoreboard bench for adder_error_sweeper (RET_LAT 0 and 2 instances)
module tb_adder_error_sweeper;
    import xpat_eval_pkg::*;

    localparam int NI = 4;
    localparam int NO = 3;

    typedef struct {
        int max_err;
        int err_cnt;
        int viol_cnt;
        int sum_err;
        int first_fail;
        int pass;
        int done_cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int   total = 0;
    int   bad = 0;
    exp_t q0[$];
    exp_t q2[$];
    int   mode = 0;
    int   lut [NVEC];

    adder_error_sweeper_if #(.N_IN(NI), .N_OUT(NO)) if0 ();
    adder_error_sweeper_if #(.N_IN(NI), .N_OUT(NO)) if2 ();

    logic          start0, abort0, busy0, done0, pass0;
    logic [NO-1:0] maxe0;
    logic [NI:0]   errc0, viol0;
    logic [NI+NO-1:0] sum0;
    logic [NI-1:0] ff0;

    logic          start2, abort2, busy2, done2, pass2;
    logic [NO-1:0] maxe2;
    logic [NI:0]   errc2, viol2;
    logic [NI+NO-1:0] sum2;
    logic [NI-1:0] ff2;

    adder_error_sweeper #(.N_IN(NI), .N_OUT(NO), .ET(2), .RET_LAT(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .bus(if0.master),
        .i_start(start0), .i_abort(abort0), .o_busy(busy0), .o_done(done0), .o_pass(pass0),
        .o_max_err(maxe0), .o_err_cnt(errc0), .o_viol_cnt(viol0), .o_sum_err(sum0),
        .o_first_fail(ff0)
    );

    adder_error_sweeper #(.N_IN(NI), .N_OUT(NO), .ET(2), .RET_LAT(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .bus(if2.master),
        .i_start(start2), .i_abort(abort2), .o_busy(busy2), .o_done(done2), .o_pass(pass2),
        .o_max_err(maxe2), .o_err_cnt(errc2), .o_viol_cnt(viol2), .o_sum_err(sum2),
        .o_first_fail(ff2)
    );

    // Behavioural approximate adders driven into dut0
    function automatic int approx_of(input int m, input int v);
        int ex;
        ex = (v % 4) + (v / 4);
        case (m)
            0:       return ex;
            1:       return 0;
            2:       return ex ^ 2;
            default: return lut[v];
        endcase
    endfunction

    assign if0.approx_out = 3'(approx_of(mode, int'(if0.stim)));

    // Two-stage registered exact adder for the RET_LAT=2 instance
    logic [2:0] ad1, ad2;
    always @(posedge clk) begin
        ad1 <= 3'(if2.stim[1:0]) + 3'(if2.stim[3:2]);
        ad2 <= ad1;
    end
    assign if2.approx_out = ad2;

    // Reference: statistics over all 16 vectors from plain arithmetic
    function automatic exp_t model(input int m, input int dc);
        exp_t e;
        e = exp_t'{0, 0, 0, 0, 0, 0, dc};
        for (int v = 0; v < NVEC; v++) begin
            int ex, ap, er;
            ex = (v % 4) + (v / 4);
            ap = approx_of(m, v);
            er = (ex > ap) ? ex - ap : ap - ex;
            if (er > e.max_err) e.max_err = er;
            if (er != 0) e.err_cnt++;
            if (er > 2) begin
                if (e.viol_cnt == 0) e.first_fail = v;
                e.viol_cnt++;
            end
            e.sum_err += er;
        end
        e.pass = (e.viol_cnt == 0) ? 1 : 0;
        return e;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s act=%0d exp=%0d (cyc %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic cmp_res(input string tg, input exp_t e, input int mx, input int ec,
                           input int vc, input int se, input int ff, input int ps);
        chk({tg, "_done_cyc"},   cyc, e.done_cyc);
        chk({tg, "_max_err"},    mx,  e.max_err);
        chk({tg, "_err_cnt"},    ec,  e.err_cnt);
        chk({tg, "_viol_cnt"},   vc,  e.viol_cnt);
        chk({tg, "_sum_err"},    se,  e.sum_err);
        chk({tg, "_first_fail"}, ff,  e.first_fail);
        chk({tg, "_pass"},       ps,  e.pass);
    endtask

    // Monitor: every done pulse pops one expectation
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && done0) begin
            if (q0.size() == 0) begin
                total++; bad++;
                $display("FAIL dut0_unexpected_done act=1 exp=0 (cyc %0d)", cyc);
            end else begin
                e = q0.pop_front();
                cmp_res("d0", e, int'(maxe0), int'(errc0), int'(viol0), int'(sum0), int'(ff0), int'(pass0));
            end
        end
        if (rst_n && done2) begin
            if (q2.size() == 0) begin
                total++; bad++;
                $display("FAIL dut2_unexpected_done act=1 exp=0 (cyc %0d)", cyc);
            end else begin
                e = q2.pop_front();
                cmp_res("d2", e, int'(maxe2), int'(errc2), int'(viol2), int'(sum2), int'(ff2), int'(pass2));
            end
        end
    end

    task automatic go(input int which, output int sc);
        @(posedge clk); #1;
        if (which == 0) start0 = 1'b1; else start2 = 1'b1;
        sc = cyc;
        @(posedge clk); #1;
        start0 = 1'b0;
        start2 = 1'b0;
    endtask

    task automatic wait_q(input int which);
        bit ok;
        int i;
        ok = 1'b0;
        i = 0;
        while (!ok && i < 100) begin
            @(negedge clk);
            if ((which == 0 && q0.size() == 0) || (which == 2 && q2.size() == 0)) ok = 1'b1;
            i++;
        end
        if (!ok) begin
            total++; bad++;
            $display("FAIL wait_done_%0d act=timeout exp=done", which);
            if (which == 0) q0.delete(); else q2.delete();
        end
    endtask

    task automatic wait_stim(input int v);
        bit ok;
        int i;
        ok = 1'b0;
        i = 0;
        while (!ok && i < 64) begin
            @(negedge clk);
            if (int'(if0.stim) == v && busy0) ok = 1'b1;
            i++;
        end
        if (!ok) begin
            total++; bad++;
            $display("FAIL wait_stim act=timeout exp=%0d", v);
        end
    endtask

    task automatic chk_zero(input string tg);
        chk({tg, "_stim"},       int'(if0.stim), 0);
        chk({tg, "_busy"},       int'(busy0),    0);
        chk({tg, "_done"},       int'(done0),    0);
        chk({tg, "_pass"},       int'(pass0),    0);
        chk({tg, "_max_err"},    int'(maxe0),    0);
        chk({tg, "_err_cnt"},    int'(errc0),    0);
        chk({tg, "_viol_cnt"},   int'(viol0),    0);
        chk({tg, "_sum_err"},    int'(sum0),     0);
        chk({tg, "_first_fail"}, int'(ff0),      0);
    endtask

    initial begin
        int sc;
        start0 = 1'b0; abort0 = 1'b0;
        start2 = 1'b0; abort2 = 1'b0;
        for (int v = 0; v < NVEC; v++) lut[v] = 0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk_zero("reset");

        // exact adder
        mode = 0;
        go(0, sc);
        q0.push_back(exp_t'{0, 0, 0, 0, 0, 1, sc + 19});
        wait_q(0);

        // output stuck at zero
        mode = 1;
        go(0, sc);
        q0.push_back(exp_t'{6, 15, 10, 48, 3, 0, sc + 19});
        wait_q(0);

        // middle bit flipped
        mode = 2;
        go(0, sc);
        q0.push_back(exp_t'{2, 16, 0, 32, 0, 1, sc + 19});
        wait_q(0);

        // RET_LAT=2 against a two-stage registered exact adder
        go(2, sc);
        q2.push_back(exp_t'{0, 0, 0, 0, 0, 1, sc + 21});
        wait_q(2);

        // random lookup-table adders checked against the reference model
        for (int r = 0; r < 6; r++) begin
            for (int v = 0; v < NVEC; v++) lut[v] = int'($urandom_range(7, 0));
            mode = 3;
            repeat ($urandom_range(3, 0)) @(posedge clk);
            go(0, sc);
            q0.push_back(model(3, sc + 19));
            wait_q(0);
        end

        // start while busy is ignored: original sweep timing and results stand
        mode = 1;
        go(0, sc);
        q0.push_back(exp_t'{6, 15, 10, 48, 3, 0, sc + 19});
        repeat (4) @(posedge clk);
        #1 start0 = 1'b1;
        @(posedge clk);
        #1 start0 = 1'b0;
        @(negedge clk);
        chk("busy_mid_sweep", int'(busy0), 1);
        wait_q(0);

        // abort when stim reaches 5: back to idle, no done, pass low
        mode = 0;
        go(0, sc);
        wait_stim(5);
        abort0 = 1'b1;
        @(posedge clk);
        #1 abort0 = 1'b0;
        @(negedge clk);
        chk("abort_busy", int'(busy0), 0);
        chk("abort_pass", int'(pass0), 0);
        repeat (30) @(posedge clk);

        // start and abort together in idle: abort wins
        @(posedge clk);
        #1 begin start0 = 1'b1; abort0 = 1'b1; end
        @(posedge clk);
        #1 begin start0 = 1'b0; abort0 = 1'b0; end
        @(negedge clk);
        chk("start_abort_busy", int'(busy0), 0);
        repeat (25) @(posedge clk);

        // reset during DRAIN clears everything at once
        mode = 1;
        go(0, sc);
        q0.push_back(exp_t'{6, 15, 10, 48, 3, 0, sc + 19});
        wait_stim(15);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1 chk_zero("rst_drain");
        q0.delete();
        @(posedge clk);
        #1 rst_n = 1'b1;

        // fresh sweep after reset matches the exact-adder result
        mode = 0;
        go(0, sc);
        q0.push_back(exp_t'{0, 0, 0, 0, 0, 1, sc + 19});
        wait_q(0);

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
